cache_control: RTL and testbench
================================

CACHE_CONTROL -- requirements
Module: cache_control

Interface
REQ-001 The block SHALL have no parameters.
REQ-002 clk  in  1  sole clock; all state updates on rising edge.
REQ-003 reset  in  1  synchronous, active-high reset.
REQ-004 mem_read  in  1  CPU read request, held until mem_resp.
REQ-005 mem_write  in  1  CPU write request, held until mem_resp.
REQ-006 hit0 / hit1  in  1 each  valid & tag match for way 0 / way 1 of the indexed set.
REQ-007 lru  in  1  LRU bit of the indexed set; names the victim way.
REQ-008 dirty_lru  in  1  dirty bit of the victim way.
REQ-009 pmem_resp  in  1  physical memory done (one-cycle pulse).
REQ-010 mem_resp  out  1  CPU request complete.
REQ-011 pmem_read / pmem_write  out  1 each  physical memory line read / write request.
REQ-012 pmem_addr_sel  out  1  0 = CPU address, 1 = victim tag + CPU index.
REQ-013 load_way  out  2  one-hot data/tag/valid write enable per way.
REQ-014 data_in_sel  out  1  0 = word-merged block (CPU write data into line), 1 = pmem line.
REQ-015 set_dirty / clear_dirty  out  1 each  dirty-bit update for the way selected by load_way.
REQ-016 load_lru / lru_in  out  1 / 1  LRU write enable and value for the indexed set.
REQ-017 hit_count / miss_count  out  16 each  performance counters.

Function
REQ-018 FSM states SHALL be IDLE, WRITEBACK, ALLOCATE; outputs default 0 in every state unless stated.
REQ-019 Request = mem_read | mem_write; simultaneous mem_read and mem_write SHALL be treated as a write.
REQ-020 IDLE, request, hit: mem_resp=1 combinationally in the same cycle; hit way = 0 if hit0 else 1 (hit0 has priority if both asserted).
REQ-021 Read hit: load_lru=1, lru_in = ~hit way; no data/tag write.
REQ-022 Write hit: additionally load_way[hit way]=1, data_in_sel=0, set_dirty=1.
REQ-023 IDLE, request, no hit, dirty_lru=1: next state WRITEBACK; dirty_lru=0: next state ALLOCATE; mem_resp=0.
REQ-024 WRITEBACK: pmem_write=1, pmem_addr_sel=1 held every cycle until pmem_resp; on pmem_resp go to ALLOCATE.
REQ-025 ALLOCATE: pmem_read=1, pmem_addr_sel=0 held until pmem_resp; in the pmem_resp cycle load_way[lru]=1, data_in_sel=1, clear_dirty=1; next state IDLE.
REQ-026 After ALLOCATE the block SHALL re-evaluate in IDLE, producing a hit one cycle later (miss latency = writeback + allocate + 1 cycle).
REQ-027 No request in IDLE: all control outputs 0, state unchanged.
REQ-028 pmem_resp outside WRITEBACK/ALLOCATE SHALL be ignored.
REQ-029 Internal flag miss_pend SHALL set on IDLE->WRITEBACK/ALLOCATE and clear on mem_resp.
REQ-030 miss_count SHALL increment once per IDLE->WRITEBACK/ALLOCATE transition.
REQ-031 hit_count SHALL increment on each mem_resp cycle with miss_pend=0.
REQ-032 Both counters SHALL saturate at 16'hFFFF (no wrap).

Reset
REQ-033 reset=1 at a clock edge SHALL force state IDLE, miss_pend=0, hit_count=0, miss_count=0 regardless of state.
REQ-034 Reset mid-WRITEBACK/ALLOCATE SHALL deassert pmem_read/pmem_write from the next cycle; the interrupted transfer is abandoned.
REQ-035 While reset is asserted, mem_resp, load_way, set_dirty, clear_dirty and load_lru SHALL be 0.

Verification
REQ-036 Read hit: mem_read=1, hit1=1 -> same cycle mem_resp=1, load_lru=1, lru_in=0, load_way=00; hit_count 0->1.
REQ-037 Write hit: mem_write=1, hit0=1 -> mem_resp=1, load_way=01, data_in_sel=0, set_dirty=1, lru_in=1.
REQ-038 Clean miss: mem_read=1, no hit, lru=1, dirty_lru=0, pmem_resp after 3 cycles -> pmem_read high 3 cycles, load_way=10 with data_in_sel=1 in the pmem_resp cycle; then hit1=1 -> mem_resp; miss_count=1, hit_count=0.
REQ-039 Dirty miss: dirty_lru=1 -> pmem_write with pmem_addr_sel=1 until pmem_resp, then pmem_read, then mem_resp; no cycle has pmem_read and pmem_write both high.
REQ-040 Reset in WRITEBACK: assert reset while pmem_write=1 -> next cycle pmem_write=0, state IDLE, counters 0.
REQ-041 Saturation: 65,536 read hits -> hit_count holds 16'hFFFF.

Source files
------------

// File: rtl/cache_control_if.sv
// Bundle of CPU-side request, datapath status and control signals for the cache controller.
// The master modport is the CPU/datapath side; the slave modport is the controller.
interface cache_control_if;
  logic        mem_read;
  logic        mem_write;
  logic        hit0;
  logic        hit1;
  logic        lru;
  logic        dirty_lru;
  logic        pmem_resp;
  logic        mem_resp;
  logic        pmem_read;
  logic        pmem_write;
  logic        pmem_addr_sel;
  logic [1:0]  load_way;
  logic        data_in_sel;
  logic        set_dirty;
  logic        clear_dirty;
  logic        load_lru;
  logic        lru_in;
  logic [15:0] hit_count;
  logic [15:0] miss_count;

  modport master (
    output mem_read, mem_write, hit0, hit1, lru, dirty_lru, pmem_resp,
    input  mem_resp, pmem_read, pmem_write, pmem_addr_sel, load_way, data_in_sel,
           set_dirty, clear_dirty, load_lru, lru_in, hit_count, miss_count
  );

  modport slave (
    input  mem_read, mem_write, hit0, hit1, lru, dirty_lru, pmem_resp,
    output mem_resp, pmem_read, pmem_write, pmem_addr_sel, load_way, data_in_sel,
           set_dirty, clear_dirty, load_lru, lru_in, hit_count, miss_count
  );
endinterface

// File: rtl/cache_control.sv
// Two-way set-associative cache controller: hit handling, dirty-victim writeback,
// line allocate from physical memory, and saturating hit/miss performance counters.
module cache_control (
  input  logic            clk,
  input  logic            reset,
  cache_control_if.slave  bus
);

  typedef enum logic [1:0] {IDLE = 2'd0, WRITEBACK = 2'd1, ALLOCATE = 2'd2} state_t;

  state_t      r_state;
  state_t      w_nextState;
  logic        r_missPend;
  logic [15:0] r_hitCount;
  logic [15:0] r_missCount;

  logic        w_req;
  logic        w_hit;
  logic        w_hitWay;
  logic        w_missStart;
  logic        w_memResp;
  logic        w_pmemRead;
  logic        w_pmemWrite;
  logic        w_pmemAddrSel;
  logic [1:0]  w_loadWay;
  logic        w_dataInSel;
  logic        w_setDirty;
  logic        w_clearDirty;
  logic        w_loadLru;
  logic        w_lruIn;

  // A simultaneous read and write is handled as a write; way 0 wins a double hit.
  assign w_req       = bus.mem_read | bus.mem_write;
  assign w_hit       = bus.hit0 | bus.hit1;
  assign w_hitWay    = ~bus.hit0;
  assign w_missStart = (r_state == IDLE) && w_req && !w_hit;

  always_ff @(posedge clk) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_nextState;
  end

  always_comb begin
    w_nextState = r_state;
    case (r_state)
      IDLE:      if (w_missStart) w_nextState = bus.dirty_lru ? WRITEBACK : ALLOCATE;
      WRITEBACK: if (bus.pmem_resp) w_nextState = ALLOCATE;
      ALLOCATE:  if (bus.pmem_resp) w_nextState = IDLE;
      default:   w_nextState = IDLE;
    endcase
  end

  // Outputs are forced quiet while reset is held so nothing is written mid-reset.
  always_comb begin
    w_memResp     = 1'b0;
    w_pmemRead    = 1'b0;
    w_pmemWrite   = 1'b0;
    w_pmemAddrSel = 1'b0;
    w_loadWay     = 2'b00;
    w_dataInSel   = 1'b0;
    w_setDirty    = 1'b0;
    w_clearDirty  = 1'b0;
    w_loadLru     = 1'b0;
    w_lruIn       = 1'b0;
    if (!reset) begin
      case (r_state)
        IDLE: begin
          if (w_req && w_hit) begin
            w_memResp = 1'b1;
            w_loadLru = 1'b1;
            w_lruIn   = ~w_hitWay;
            if (bus.mem_write) begin
              w_loadWay  = w_hitWay ? 2'b10 : 2'b01;
              w_setDirty = 1'b1;
            end
          end
        end
        WRITEBACK: begin
          w_pmemWrite   = 1'b1;
          w_pmemAddrSel = 1'b1;
        end
        ALLOCATE: begin
          w_pmemRead = 1'b1;
          if (bus.pmem_resp) begin
            w_loadWay    = bus.lru ? 2'b10 : 2'b01;
            w_dataInSel  = 1'b1;
            w_clearDirty = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // The response that ends a miss is not counted as a hit; miss_pend remembers that.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_missPend  <= 1'b0;
      r_hitCount  <= 16'h0000;
      r_missCount <= 16'h0000;
    end else begin
      if (w_missStart) begin
        r_missPend <= 1'b1;
        if (r_missCount != 16'hFFFF) r_missCount <= r_missCount + 16'd1;
      end else if (w_memResp) begin
        r_missPend <= 1'b0;
      end
      if (w_memResp && !r_missPend && (r_hitCount != 16'hFFFF))
        r_hitCount <= r_hitCount + 16'd1;
    end
  end

  assign bus.mem_resp      = w_memResp;
  assign bus.pmem_read     = w_pmemRead;
  assign bus.pmem_write    = w_pmemWrite;
  assign bus.pmem_addr_sel = w_pmemAddrSel;
  assign bus.load_way      = w_loadWay;
  assign bus.data_in_sel   = w_dataInSel;
  assign bus.set_dirty     = w_setDirty;
  assign bus.clear_dirty   = w_clearDirty;
  assign bus.load_lru      = w_loadLru;
  assign bus.lru_in        = w_lruIn;
  assign bus.hit_count     = r_hitCount;
  assign bus.miss_count    = r_missCount;

endmodule

// File: tb/tb_cache_control.sv
// Scoreboard bench for cache_control: transactions are modelled at request level and
// the expected response is queued; a monitor checks every DUT response and memory cycle.
module tb_cache_control;

  logic clk = 1'b0;
  logic reset;

  cache_control_if bus ();

  cache_control dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0] loadWay;
    logic       setDirty;
    logic       lruIn;
    logic       victim;
    int         wbCycles;
    int         allocCycles;
    int         hitCnt;
    int         missCnt;
  } exp_t;

  exp_t expQ[$];
  exp_t monExp;
  int   checks = 0;
  int   errors = 0;
  int   modelHits = 0;
  int   modelMisses = 0;
  int   wbSeen = 0;
  int   allocSeen = 0;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s actual=%0h expected=%0h at %0t", name, actual, expected, $time);
    end
  endtask

  // Request-level reference: a miss counts once and its closing response is not a hit.
  task automatic pushExpect(input logic isWrite, input logic isHit, input logic way,
                            input logic victim, input int wb, input int alloc);
    exp_t e;
    e.loadWay  = isWrite ? (way ? 2'b10 : 2'b01) : 2'b00;
    e.setDirty = isWrite;
    e.lruIn    = ~way;
    e.victim   = victim;
    e.wbCycles = wb;
    e.allocCycles = alloc;
    if (!isHit && modelMisses < 65535) modelMisses++;
    e.hitCnt  = modelHits;
    e.missCnt = modelMisses;
    if (isHit && modelHits < 65535) modelHits++;
    expQ.push_back(e);
  endtask

  task automatic clearInputs();
    bus.mem_read  = 1'b0;
    bus.mem_write = 1'b0;
    bus.hit0      = 1'b0;
    bus.hit1      = 1'b0;
    bus.lru       = 1'b0;
    bus.dirty_lru = 1'b0;
    bus.pmem_resp = 1'b0;
  endtask

  task automatic waitCycles(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // One complete CPU transaction; acts as physical memory with the given latencies.
  task automatic applyStimulus(input logic rd, input logic wr, input logic h0, input logic h1,
                               input logic lruV, input logic dirtyV, input int dW, input int dA);
    logic isHit;
    logic way;
    isHit = h0 | h1;
    way   = isHit ? ~h0 : lruV;
    pushExpect(wr, isHit, way, lruV, (!isHit && dirtyV) ? dW : 0, isHit ? 0 : dA);
    bus.mem_read  = rd;
    bus.mem_write = wr;
    bus.hit0      = h0;
    bus.hit1      = h1;
    bus.lru       = lruV;
    bus.dirty_lru = dirtyV;
    waitCycles(1);
    if (!isHit) begin
      if (dirtyV) begin
        waitCycles(dW - 1);
        bus.pmem_resp = 1'b1;
        waitCycles(1);
        bus.pmem_resp = 1'b0;
      end
      waitCycles(dA - 1);
      bus.pmem_resp = 1'b1;
      waitCycles(1);
      bus.pmem_resp = 1'b0;
      bus.hit0 = ~lruV;
      bus.hit1 = lruV;
      waitCycles(1);
    end
    clearInputs();
  endtask

  // Monitor: checks every memory cycle and pops one expectation per CPU response.
  always @(negedge clk) begin
    if (reset) begin
      wbSeen    = 0;
      allocSeen = 0;
    end else begin
      if (bus.pmem_read | bus.pmem_write)
        checkOutput("pmemExclusive", 32'(bus.pmem_read & bus.pmem_write), 32'd0);
      if (bus.pmem_write) begin
        wbSeen++;
        checkOutput("wbAddrSel", 32'(bus.pmem_addr_sel), 32'd1);
      end
      if (bus.pmem_read) begin
        allocSeen++;
        checkOutput("allocAddrSel", 32'(bus.pmem_addr_sel), 32'd0);
        if (bus.pmem_resp && expQ.size() > 0) begin
          checkOutput("allocLoadWay", 32'(bus.load_way), expQ[0].victim ? 32'd2 : 32'd1);
          checkOutput("allocDataSel", 32'(bus.data_in_sel), 32'd1);
          checkOutput("allocClearDirty", 32'(bus.clear_dirty), 32'd1);
        end
      end
      if (bus.mem_resp) begin
        if (expQ.size() == 0) begin
          checkOutput("unexpectedResp", 32'(bus.mem_resp), 32'd0);
        end else begin
          monExp = expQ.pop_front();
          checkOutput("respLoadWay", 32'(bus.load_way), 32'(monExp.loadWay));
          checkOutput("respSetDirty", 32'(bus.set_dirty), 32'(monExp.setDirty));
          checkOutput("respDataSel", 32'(bus.data_in_sel), 32'd0);
          checkOutput("respClearDirty", 32'(bus.clear_dirty), 32'd0);
          checkOutput("respLoadLru", 32'(bus.load_lru), 32'd1);
          checkOutput("respLruIn", 32'(bus.lru_in), 32'(monExp.lruIn));
          checkOutput("wbCycles", 32'(wbSeen), 32'(monExp.wbCycles));
          checkOutput("allocCycles", 32'(allocSeen), 32'(monExp.allocCycles));
          checkOutput("respHitCount", 32'(bus.hit_count), 32'(monExp.hitCnt));
          checkOutput("respMissCount", 32'(bus.miss_count), 32'(monExp.missCnt));
        end
        wbSeen    = 0;
        allocSeen = 0;
      end
    end
  end

  initial begin
    #1_500_000;
    $display("[TB] FAIL watchdog expired checks=%0d errors=%0d", checks, errors);
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    logic rd, wr, h0, h1;
    int   op, hsel;
    clearInputs();
    reset = 1'b1;
    bus.mem_read  = 1'b1;
    bus.mem_write = 1'b1;
    bus.hit0      = 1'b1;
    waitCycles(2);
    @(negedge clk);
    checkOutput("resetQuiet", {27'd0, bus.mem_resp, bus.load_way, bus.set_dirty, bus.load_lru}, 32'd0);
    checkOutput("resetClearDirty", 32'(bus.clear_dirty), 32'd0);
    @(posedge clk);
    #1;
    clearInputs();
    reset = 1'b0;
    @(negedge clk);
    checkOutput("resetHitCount", 32'(bus.hit_count), 32'd0);
    checkOutput("resetMissCount", 32'(bus.miss_count), 32'd0);
    @(posedge clk);
    #1;

    applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1, 1);
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1, 1);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1, 3);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 2, 2);
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1, 1);

    for (int n = 0; n < 250; n++) begin
      op   = int'($urandom_range(0, 2));
      hsel = int'($urandom_range(0, 3));
      rd   = (op != 1);
      wr   = (op != 0);
      h0   = (hsel == 1) || (hsel == 3);
      h1   = (hsel == 2) || (hsel == 3);
      applyStimulus(rd, wr, h0, h1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                    int'($urandom_range(1, 4)), int'($urandom_range(1, 4)));
      repeat ($urandom_range(0, 2)) begin
        bus.pmem_resp = 1'($urandom_range(0, 1));
        bus.hit0      = 1'($urandom_range(0, 1));
        bus.hit1      = 1'($urandom_range(0, 1));
        bus.dirty_lru = 1'($urandom_range(0, 1));
        @(negedge clk);
        checkOutput("idleQuiet", {27'd0, bus.mem_resp, bus.load_lru, bus.load_way, bus.pmem_read | bus.pmem_write}, 32'd0);
        @(posedge clk);
        #1;
        clearInputs();
      end
    end

    // Reset while a writeback is in flight abandons the transfer.
    bus.mem_read  = 1'b1;
    bus.dirty_lru = 1'b1;
    waitCycles(1);
    @(negedge clk);
    checkOutput("wbActive", 32'(bus.pmem_write), 32'd1);
    @(posedge clk);
    #1;
    reset = 1'b1;
    clearInputs();
    waitCycles(1);
    reset = 1'b0;
    modelHits   = 0;
    modelMisses = 0;
    @(negedge clk);
    checkOutput("rstWbPmemWrite", 32'(bus.pmem_write), 32'd0);
    checkOutput("rstWbPmemRead", 32'(bus.pmem_read), 32'd0);
    checkOutput("rstWbHitCount", 32'(bus.hit_count), 32'd0);
    checkOutput("rstWbMissCount", 32'(bus.miss_count), 32'd0);
    @(posedge clk);
    #1;
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1, 1);

    // Back-to-back read hits drive hit_count into saturation.
    bus.mem_read = 1'b1;
    bus.hit0     = 1'b1;
    for (int i = 0; i < 65536; i++) begin
      pushExpect(1'b0, 1'b1, 1'b0, 1'b0, 0, 0);
      waitCycles(1);
    end
    clearInputs();
    @(negedge clk);
    checkOutput("satHold", 32'(bus.hit_count), 32'h0000FFFF);
    @(posedge clk);
    #1;
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1, 1);
    waitCycles(3);
    @(negedge clk);
    checkOutput("satFinal", 32'(bus.hit_count), 32'h0000FFFF);
    checkOutput("queueDrained", 32'(expQ.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
